// File: rtl/vga_pic_ram_loader.sv
// vga_pic_ram_loader
// Pairs a UART byte stream (high byte first) into RGB565 pixels and writes
// them in raster order into the picture RAM write port. Handles address
// sequencing, frame wrap, restart on clr, and idle-timeout resynchronisation.
module vga_pic_ram_loader #(
   parameter int PIC_W    = 100,
   parameter int PIC_H    = 100,
   parameter int PIC_SIZE = PIC_W * PIC_H,
   parameter int ADDR_W   = 14,
   parameter int TIMEOUT  = 50000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_flag,
   input  logic              clr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              loading,
   output logic              frame_done,
   output logic              err_timeout
);

   localparam int                IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIC_SIZE - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

   typedef enum logic {
      S_HI = 1'b0,  // expecting the high byte of a pixel
      S_LO = 1'b1   // high byte held, expecting the low byte
   } state_t;

   state_t            state, state_nxt;
   logic [7:0]        hi_q, hi_nxt;
   logic [ADDR_W-1:0] pix_cnt, pix_nxt;
   logic [IDLE_W-1:0] idle_cnt, idle_nxt;
   logic              wr_en_nxt;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [15:0]       wr_data_nxt;
   logic              loading_nxt;
   logic              frame_done_nxt;
   logic              err_timeout_nxt;

   // State, counters and all outputs are registered; reset clears everything.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= S_HI;
         hi_q        <= '0;
         pix_cnt     <= '0;
         idle_cnt    <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         loading     <= 1'b0;
         frame_done  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state       <= state_nxt;
         hi_q        <= hi_nxt;
         pix_cnt     <= pix_nxt;
         idle_cnt    <= idle_nxt;
         wr_en       <= wr_en_nxt;
         wr_addr     <= wr_addr_nxt;
         wr_data     <= wr_data_nxt;
         loading     <= loading_nxt;
         frame_done  <= frame_done_nxt;
         err_timeout <= err_timeout_nxt;
      end
   end

   // Next-state logic: clr beats rx_flag, rx_flag beats the idle timeout.
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_nxt       = state;
      hi_nxt          = hi_q;
      pix_nxt         = pix_cnt;
      idle_nxt        = idle_cnt;
      wr_en_nxt       = 1'b0;
      wr_addr_nxt     = wr_addr;
      wr_data_nxt     = wr_data;
      frame_done_nxt  = 1'b0;
      err_timeout_nxt = 1'b0;

      if (clr) begin
         // Restart the frame silently; a byte arriving now is dropped.
         state_nxt = S_HI;
         hi_nxt    = '0;
         pix_nxt   = '0;
         idle_nxt  = '0;
      end else if (rx_flag) begin
         idle_nxt = '0;
         if (state == S_HI) begin
            hi_nxt    = rx_data;
            state_nxt = S_LO;
         end else begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = pix_cnt;
            wr_data_nxt = {hi_q, rx_data};
            state_nxt   = S_HI;
            if (pix_cnt == LAST_PIX) begin
               pix_nxt        = '0;
               frame_done_nxt = 1'b1;
            end else begin
               pix_nxt = pix_cnt + 1'b1;
            end
         end
      end else if (loading && (idle_cnt == IDLE_MAX)) begin
         // Line went quiet mid-frame: drop the partial frame and resync.
         state_nxt       = S_HI;
         hi_nxt          = '0;
         pix_nxt         = '0;
         idle_nxt        = '0;
         err_timeout_nxt = 1'b1;
      end else if (loading) begin
         // Below IDLE_MAX here, so the increment can never wrap.
         idle_nxt = idle_cnt + 1'b1;
      end else begin
         idle_nxt = '0;
      end

      loading_nxt = (state_nxt == S_LO) || (pix_nxt != '0);
   end

endmodule

// File: tb/tb_vga_pic_ram_loader.sv
// Bench for vga_pic_ram_loader: reset, vector table for two back-to-back
// frames, hand-written timeout / clr corner cases, then random traffic
// compared against a byte-count reference model.
module tb_vga_pic_ram_loader;

   localparam int PIC_W    = 4;
   localparam int PIC_H    = 2;
   localparam int PIC_SIZE = PIC_W * PIC_H;
   localparam int ADDR_W   = 3;
   localparam int TIMEOUT  = 16;
   localparam int NVEC     = 34;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic [7:0]        rx_data;
   logic              rx_flag;
   logic              clr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              loading;
   logic              frame_done;
   logic              err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   vga_pic_ram_loader #(
      .PIC_W   (PIC_W),
      .PIC_H   (PIC_H),
      .PIC_SIZE(PIC_SIZE),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .rx_data    (rx_data),
      .rx_flag    (rx_flag),
      .clr        (clr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .loading    (loading),
      .frame_done (frame_done),
      .err_timeout(err_timeout)
   );

   always #10 sys_clk = ~sys_clk;

   // Reference model: a frame is just a count of bytes received so far;
   // the idle timeout is measured as clock edges since the last byte.
   int                m_nbytes;
   int                m_cyc;
   int                m_last;
   logic [7:0]        m_hi;
   logic [ADDR_W-1:0] m_addr;
   logic [15:0]       m_data;
   bit                e_we, e_fd, e_err, e_loading;

   function automatic void model_reset();
      m_nbytes = 0; m_cyc = 0; m_last = 0; m_hi = '0;
      m_addr = '0; m_data = '0;
      e_we = 0; e_fd = 0; e_err = 0; e_loading = 0;
   endfunction

   function automatic void model_step(input bit f, input logic [7:0] d, input bit c);
      bit was_loading;
      was_loading = (m_nbytes != 0);
      m_cyc++;
      e_we = 0; e_fd = 0; e_err = 0;
      if (c) begin
         m_nbytes = 0;
      end else if (f) begin
         m_last = m_cyc;
         if (m_nbytes % 2 == 0) begin
            m_hi = d;
         end else begin
            m_addr = ADDR_W'(m_nbytes / 2);
            m_data = {m_hi, d};
            e_we   = 1;
         end
         m_nbytes++;
         if (m_nbytes == 2 * PIC_SIZE) begin
            m_nbytes = 0;
            e_fd     = 1;
         end
      end else if (was_loading && (m_cyc - m_last) == TIMEOUT) begin
         m_nbytes = 0;
         e_err    = 1;
      end
      e_loading = (m_nbytes != 0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive at the falling edge, DUT samples at the rising edge,
   // outputs are then observed at the following falling edge.
   task automatic step(input bit f, input logic [7:0] d, input bit c);
      rx_flag = f; rx_data = d; clr = c;
      @(posedge sys_clk);
      model_step(f, d, c);
      @(negedge sys_clk);
      rx_flag = 1'b0; clr = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_we"},      32'(wr_en),       32'(e_we));
      check({tag, "_addr"},    32'(wr_addr),     32'(m_addr));
      check({tag, "_data"},    32'(wr_data),     32'(m_data));
      check({tag, "_loading"}, 32'(loading),     32'(e_loading));
      check({tag, "_fdone"},   32'(frame_done),  32'(e_fd));
      check({tag, "_err"},     32'(err_timeout), 32'(e_err));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_we"},      32'(wr_en),       0);
      check({tag, "_addr"},    32'(wr_addr),     0);
      check({tag, "_data"},    32'(wr_data),     0);
      check({tag, "_loading"}, 32'(loading),     0);
      check({tag, "_fdone"},   32'(frame_done),  0);
      check({tag, "_err"},     32'(err_timeout), 0);
   endtask

   task automatic send_pixels(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 8'(base + 2 * i), 1'b0);
         step(1'b1, 8'(base + 2 * i + 1), 1'b0);
      end
   endtask

   typedef struct {
      bit                flag;
      logic [7:0]        d;
      bit                c;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
      bit                ld;
      bit                fd;
      bit                err;
   } vec_t;

   vec_t              vecs [NVEC];
   logic [ADDR_W-1:0] hold_addr;
   logic [15:0]       hold_data;

   initial begin
      // Two back-to-back frames of bytes 0x00..0x0F, then two idle clocks.
      hold_addr = '0;
      hold_data = '0;
      for (int i = 0; i < NVEC; i++) begin
         int b;
         b = i % 16;
         vecs[i].c   = 0;
         vecs[i].err = 0;
         if (i < 32) begin
            vecs[i].flag = 1;
            vecs[i].d    = 8'(b);
            vecs[i].we   = (b % 2 == 1);
            if (b % 2 == 1) begin
               hold_addr = ADDR_W'(b / 2);
               hold_data = {8'(b - 1), 8'(b)};
            end
            vecs[i].ld = (b != 15);
            vecs[i].fd = (b == 15);
         end else begin
            vecs[i].flag = 0;
            vecs[i].d    = '0;
            vecs[i].we   = 0;
            vecs[i].ld   = 0;
            vecs[i].fd   = 0;
         end
         vecs[i].addr = hold_addr;
         vecs[i].data = hold_data;
      end

      // Reset
      rx_flag = 1'b0; rx_data = '0; clr = 1'b0;
      sys_rst = 1'b1;
      model_reset();
      #100;
      check_zero("rst_held");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check_zero("rst_rel");
      model_reset();

      // Full frame followed immediately by a wrapped second frame
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].flag, vecs[i].d, vecs[i].c);
         check($sformatf("tbl%0d_we", i),      32'(wr_en),       32'(vecs[i].we));
         check($sformatf("tbl%0d_addr", i),    32'(wr_addr),     32'(vecs[i].addr));
         check($sformatf("tbl%0d_data", i),    32'(wr_data),     32'(vecs[i].data));
         check($sformatf("tbl%0d_loading", i), 32'(loading),     32'(vecs[i].ld));
         check($sformatf("tbl%0d_fdone", i),   32'(frame_done),  32'(vecs[i].fd));
         check($sformatf("tbl%0d_err", i),     32'(err_timeout), 32'(vecs[i].err));
      end

      // Half-pixel timeout: pulse exactly 16 clocks after the lone byte
      step(1'b1, 8'hAB, 1'b0);
      check("s4_loading_hi", 32'(loading), 1);
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 8'h00, 1'b0);
         check($sformatf("s4_err_k%0d", k), 32'(err_timeout), 32'(k == TIMEOUT));
         check($sformatf("s4_we_k%0d", k),  32'(wr_en), 0);
         if (k == TIMEOUT) check("s4_loading_drop", 32'(loading), 0);
      end
      step(1'b1, 8'h12, 1'b0);
      step(1'b1, 8'h34, 1'b0);
      check("s4_we",   32'(wr_en),   1);
      check("s4_addr", 32'(wr_addr), 0);
      check("s4_data", 32'(wr_data), 32'h1234);
      step(1'b0, 8'h00, 1'b1);

      // Mid-frame timeout after 3 pixels
      send_pixels(3, 8'h40);
      check("s5a_addr_last", 32'(wr_addr), 2);
      for (int k = 1; k <= TIMEOUT; k++) begin
         step(1'b0, 8'h00, 1'b0);
         check($sformatf("s5a_err_k%0d", k), 32'(err_timeout), 32'(k == TIMEOUT));
      end
      check("s5a_loading", 32'(loading), 0);
      send_pixels(1, 8'h50);
      check("s5a_next_we",   32'(wr_en),   1);
      check("s5a_next_addr", 32'(wr_addr), 0);
      step(1'b0, 8'h00, 1'b1);

      // Byte arriving on the last idle cycle wins over the timeout
      send_pixels(3, 8'h60);
      for (int k = 1; k < TIMEOUT; k++) begin
         step(1'b0, 8'h00, 1'b0);
         check($sformatf("s5b_err_k%0d", k), 32'(err_timeout), 0);
      end
      step(1'b1, 8'hC3, 1'b0);
      check("s5b_noabort_err", 32'(err_timeout), 0);
      check("s5b_loading",     32'(loading),     1);
      step(1'b1, 8'h3C, 1'b0);
      check("s5b_we",   32'(wr_en),   1);
      check("s5b_addr", 32'(wr_addr), 3);
      check("s5b_data", 32'(wr_data), 32'hC33C);
      step(1'b0, 8'h00, 1'b1);

      // clr coincident with a low byte after 2 pixels
      send_pixels(2, 8'h70);
      step(1'b1, 8'h99, 1'b0);
      step(1'b1, 8'h88, 1'b1);
      check("s6_we",      32'(wr_en),       0);
      check("s6_err",     32'(err_timeout), 0);
      check("s6_loading", 32'(loading),     0);
      check_model("s6");
      send_pixels(1, 8'h20);
      check("s6_next_addr", 32'(wr_addr), 0);
      check("s6_next_data", 32'(wr_data), 32'h2021);

      // Reset mid-frame discards the partial frame at once
      step(1'b1, 8'h55, 1'b0);
      #2 sys_rst = 1'b1;
      #1 check_zero("rst_mid");
      model_reset();
      #2 sys_rst = 1'b0;
      @(negedge sys_clk);
      check_model("rst_mid_after");

      // Random traffic with periodic idle stretches and rare clr
      for (int n = 0; n < 800; n++) begin
         bit f, c;
         f = ((n % 97) > 75) ? 1'b0 : ($urandom_range(0, 99) < 70);
         c = ($urandom_range(0, 99) < 2);
         step(f, 8'($urandom_range(0, 255)), c);
         check_model("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
